// File: rtl/acl2_pkg.sv
// Shared constants for the ACL2 register-model SPI responder: opcodes, register map,
// writable RAM window and FSM state encoding.
package acl2_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h0A;
   localparam logic [7:0] CMD_READ  = 8'h0B;

   localparam logic [7:0] ADDR_DEVID_AD  = 8'h00;
   localparam logic [7:0] ADDR_DEVID_MST = 8'h01;
   localparam logic [7:0] ADDR_PARTID    = 8'h02;
   localparam logic [7:0] ADDR_REVID     = 8'h03;
   localparam logic [7:0] ADDR_XDATA     = 8'h08;
   localparam logic [7:0] ADDR_YDATA     = 8'h09;
   localparam logic [7:0] ADDR_ZDATA     = 8'h0A;
   localparam logic [7:0] ADDR_STATUS    = 8'h0B;

   localparam logic [7:0] ID_DEVID_AD  = 8'hAD;
   localparam logic [7:0] ID_DEVID_MST = 8'h1D;
   localparam logic [7:0] ID_PARTID    = 8'hF2;
   localparam logic [7:0] ID_REVID     = 8'h01;

   localparam logic [7:0] WR_LO     = 8'h10;
   localparam logic [7:0] WR_HI     = 8'h3F;
   localparam int         RAM_DEPTH = int'(WR_HI) - int'(WR_LO) + 1;
   localparam int         RAM_AW    = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_RDATA,
      ST_IGNORE
   } state_t;

   function automatic logic is_writable(input logic [7:0] a);
      return (a >= WR_LO) && (a <= WR_HI);
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Pin synchronizer (STAGES >= 2 flops) plus registered rise/fall detect.
// Level and edge outputs are aligned: both appear STAGES+1 clocks after the pin moves.
module spi_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              lvl_q;
   logic              rise_q;
   logic              fall_q;

   // The chain and level keep tracking the pin through reset, so a line that is
   // already low when reset releases produces no spurious edge afterwards.
   always_ff @(posedge clk_i) begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      lvl_q  <= sync_q[STAGES-1];
      if (rst_i) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= sync_q[STAGES-1] & ~lvl_q;
         fall_q <= ~sync_q[STAGES-1] & lvl_q;
      end
   end

   assign lvl_o  = lvl_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/spi_acl2_responder.sv
// SPI mode-0 slave modelling the ACL2 register interface, oversampled in the CLK domain.
// Pin-to-event latency SYNC_STAGES+1 clocks; MISO and WR_STROBE register one clock after the event.
module spi_acl2_responder
   import acl2_pkg::*;
#(
   parameter int ADDR_W      = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              SCLK,
   input  logic              CS,
   input  logic              MOSI,
   output logic              MISO,
   output logic              MISO_OE,
   input  logic [7:0]        X_DATA,
   input  logic [7:0]        Y_DATA,
   input  logic [7:0]        Z_DATA,
   input  logic              DATA_READY,
   output logic              WR_STROBE,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [7:0]        WR_DATA,
   output logic              BUSY
);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk_i(CLK), .rst_i(RESET), .pin_i(SCLK),
      .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .clk_i(CLK), .rst_i(RESET), .pin_i(CS),
      .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
   );
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk_i(CLK), .rst_i(RESET), .pin_i(MOSI),
      .lvl_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{sclk_lvl, cs_rise, mosi_rise, mosi_fall};

   state_t            state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        rx_q, rx_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              wr_flag_q, wr_flag_d;
   logic [7:0]        tx_q, tx_d;
   logic [2:0]        tx_cnt_q, tx_cnt_d;
   logic              first_q, first_d;
   logic              miso_q, miso_d;
   logic              strobe_q, strobe_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              busy_q;
   logic              ram_we;
   logic [7:0]        ram_q [RAM_DEPTH];

   logic [7:0]        rx_byte;
   logic              byte_done;
   logic [ADDR_W-1:0] ptr_inc;
   logic [7:0]        rd_addr;
   logic [7:0]        rd_byte;
   logic [RAM_AW-1:0] rd_idx;
   logic [RAM_AW-1:0] wr_idx;

   assign rx_byte   = {rx_q[6:0], mosi_lvl};
   assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
   assign ptr_inc   = ptr_q + ADDR_W'(1);
   // The first byte of a read burst is fetched as the address byte completes.
   assign rd_addr   = (state_q == ST_ADDR) ? 8'(rx_byte[ADDR_W-1:0]) : 8'(ptr_inc);
   assign rd_idx    = RAM_AW'(rd_addr - WR_LO);
   assign wr_idx    = RAM_AW'(8'(ptr_q) - WR_LO);

   always_comb begin
      rd_byte = 8'h00;
      case (rd_addr)
         ADDR_DEVID_AD:  rd_byte = ID_DEVID_AD;
         ADDR_DEVID_MST: rd_byte = ID_DEVID_MST;
         ADDR_PARTID:    rd_byte = ID_PARTID;
         ADDR_REVID:     rd_byte = ID_REVID;
         ADDR_XDATA:     rd_byte = X_DATA;
         ADDR_YDATA:     rd_byte = Y_DATA;
         ADDR_ZDATA:     rd_byte = Z_DATA;
         ADDR_STATUS:    rd_byte = {7'b0, DATA_READY};
         default:        if (is_writable(rd_addr)) rd_byte = ram_q[rd_idx];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      ptr_d     = ptr_q;
      wr_flag_d = wr_flag_q;
      tx_d      = tx_q;
      tx_cnt_d  = tx_cnt_q;
      first_d   = first_q;
      miso_d    = 1'b0;
      strobe_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ram_we    = 1'b0;

      // CS high overrides everything, including an 8th SCLK edge in the same cycle.
      if (cs_lvl) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_d   = ST_CMD;
                  bit_cnt_d = 3'd0;
               end
            end
            ST_CMD: begin
               if (sclk_rise) begin
                  rx_d      = rx_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
               if (byte_done) begin
                  if (rx_byte == CMD_WRITE) begin
                     state_d   = ST_ADDR;
                     wr_flag_d = 1'b1;
                  end else if (rx_byte == CMD_READ) begin
                     state_d   = ST_ADDR;
                     wr_flag_d = 1'b0;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            ST_ADDR: begin
               if (sclk_rise) begin
                  rx_d      = rx_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
               if (byte_done) begin
                  ptr_d = rx_byte[ADDR_W-1:0];
                  if (wr_flag_q) begin
                     state_d = ST_WDATA;
                  end else begin
                     state_d  = ST_RDATA;
                     tx_d     = rd_byte;
                     tx_cnt_d = 3'd0;
                     first_d  = 1'b1;
                  end
               end
            end
            ST_WDATA: begin
               if (sclk_rise) begin
                  rx_d      = rx_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
               if (byte_done) begin
                  if (is_writable(8'(ptr_q))) begin
                     ram_we    = 1'b1;
                     strobe_d  = 1'b1;
                     wr_addr_d = ptr_q;
                     wr_data_d = rx_byte;
                  end
                  ptr_d = ptr_inc;
               end
            end
            ST_RDATA: begin
               miso_d = miso_q;
               if (sclk_fall) begin
                  if ((tx_cnt_q == 3'd0) && !first_q) begin
                     ptr_d  = ptr_inc;
                     miso_d = rd_byte[7];
                     tx_d   = {rd_byte[6:0], 1'b0};
                  end else begin
                     miso_d = tx_q[7];
                     tx_d   = {tx_q[6:0], 1'b0};
                  end
                  tx_cnt_d = tx_cnt_q + 3'd1;
                  first_d  = 1'b0;
               end
            end
            ST_IGNORE: ;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         rx_q      <= '0;
         ptr_q     <= '0;
         wr_flag_q <= 1'b0;
         tx_q      <= '0;
         tx_cnt_q  <= '0;
         first_q   <= 1'b0;
         miso_q    <= 1'b0;
         strobe_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         rx_q      <= rx_d;
         ptr_q     <= ptr_d;
         wr_flag_q <= wr_flag_d;
         tx_q      <= tx_d;
         tx_cnt_q  <= tx_cnt_d;
         first_q   <= first_d;
         miso_q    <= miso_d;
         strobe_q  <= strobe_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= ~cs_lvl;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= 8'h00;
      end else if (ram_we) begin
         ram_q[wr_idx] <= rx_byte;
      end
   end

   assign MISO      = miso_q;
   assign MISO_OE   = busy_q;
   assign BUSY      = busy_q;
   assign WR_STROBE = strobe_q;
   assign WR_ADDR   = wr_addr_q;
   assign WR_DATA   = wr_data_q;

endmodule

// File: tb/tb_spi_acl2_responder.sv
// Directed bench for spi_acl2_responder: a bit-banged SPI master drives frames, and
// monitors compare captured MISO bytes and write strobes against expected queues.
module tb_spi_acl2_responder;

   localparam int HALF = 8;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       SCLK;
   logic       CS;
   logic       MOSI;
   logic       MISO;
   logic       MISO_OE;
   logic [7:0] X_DATA;
   logic [7:0] Y_DATA;
   logic [7:0] Z_DATA;
   logic       DATA_READY;
   logic       WR_STROBE;
   logic [5:0] WR_ADDR;
   logic [7:0] WR_DATA;
   logic       BUSY;

   spi_acl2_responder #(.ADDR_W(6), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .RESET(RESET), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
      .MISO(MISO), .MISO_OE(MISO_OE),
      .X_DATA(X_DATA), .Y_DATA(Y_DATA), .Z_DATA(Z_DATA), .DATA_READY(DATA_READY),
      .WR_STROBE(WR_STROBE), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY)
   );

   always #4 CLK = ~CLK;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  exp_rd[$];
   logic [7:0]  got_rd[$];
   logic [13:0] exp_wr[$];
   logic [7:0]  tx_bytes[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Write-strobe monitor and MISO byte monitor.
   always @(negedge CLK) begin
      logic [13:0] e;
      if (WR_STROBE === 1'b1) begin
         if (exp_wr.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wr_strobe_unexpected: addr 0x%0h data 0x%0h, expected no strobe", WR_ADDR, WR_DATA);
         end else begin
            e = exp_wr.pop_front();
            check("wr_addr", 32'(WR_ADDR), 32'(e[13:8]));
            check("wr_data", 32'(WR_DATA), 32'(e[7:0]));
         end
      end
      if (got_rd.size() > 0) begin
         if (exp_rd.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL miso_byte_unexpected: got 0x%0h, expected none", got_rd.pop_front());
         end else begin
            check("miso_byte", 32'(got_rd.pop_front()), 32'(exp_rd.pop_front()));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic clk_wait(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic cs_low();
      CS = 1'b0;
      clk_wait(HALF);
   endtask

   task automatic cs_high();
      clk_wait(HALF);
      CS = 1'b1;
      clk_wait(12);
      check("miso_oe_idle", 32'(MISO_OE), 0);
      check("miso_idle", 32'(MISO), 0);
   endtask

   task automatic xfer_bit(input logic b, output logic m, input logic chk_oe);
      MOSI = b;
      clk_wait(HALF);
      SCLK = 1'b1;
      m = MISO;
      if (chk_oe) check("miso_oe_in_frame", 32'(MISO_OE), 1);
      clk_wait(HALF);
      SCLK = 1'b0;
   endtask

   task automatic xfer_byte(input logic [7:0] b, output logic [7:0] m);
      logic mb;
      for (int i = 7; i >= 0; i--) begin
         xfer_bit(b[i], mb, 1'b1);
         m[i] = mb;
      end
   endtask

   task automatic frame(input int extra_bits);
      logic [7:0] b;
      logic [7:0] m;
      logic       mb;
      cs_low();
      while (tx_bytes.size() > 0) begin
         b = tx_bytes.pop_front();
         xfer_byte(b, m);
         got_rd.push_back(m);
      end
      for (int i = 0; i < extra_bits; i++) xfer_bit(1'b1, mb, 1'b1);
      cs_high();
   endtask

   task automatic do_read(input logic [7:0] addr, input logic [7:0] e);
      exp_rd.push_back(8'h00);
      exp_rd.push_back(8'h00);
      exp_rd.push_back(e);
      tx_bytes.push_back(8'h0B);
      tx_bytes.push_back(addr);
      tx_bytes.push_back(8'hFF);
      frame(0);
   endtask

   initial begin
      logic [7:0] m;
      logic       mb;

      RESET = 1'b1; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
      X_DATA = 8'h00; Y_DATA = 8'h00; Z_DATA = 8'h00; DATA_READY = 1'b0;
      clk_wait(5);
      check("rst_miso", 32'(MISO), 0);
      check("rst_miso_oe", 32'(MISO_OE), 0);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_wr_strobe", 32'(WR_STROBE), 0);
      check("rst_wr_addr", 32'(WR_ADDR), 0);
      check("rst_wr_data", 32'(WR_DATA), 0);
      RESET = 1'b0;
      clk_wait(5);

      // ID register single read and a 4-byte burst
      do_read(8'h00, 8'hAD);
      exp_rd.push_back(8'h00); exp_rd.push_back(8'h00);
      exp_rd.push_back(8'hAD); exp_rd.push_back(8'h1D);
      exp_rd.push_back(8'hF2); exp_rd.push_back(8'h01);
      tx_bytes.push_back(8'h0B); tx_bytes.push_back(8'h00);
      repeat (4) tx_bytes.push_back(8'hFF);
      frame(0);

      // Single write then read back
      exp_rd.push_back(8'h00); exp_rd.push_back(8'h00); exp_rd.push_back(8'h00);
      exp_wr.push_back({6'h20, 8'h55});
      tx_bytes.push_back(8'h0A); tx_bytes.push_back(8'h20); tx_bytes.push_back(8'h55);
      frame(0);
      do_read(8'h20, 8'h55);

      // Burst write crossing the top of the map: 0x00 is read-only
      repeat (4) exp_rd.push_back(8'h00);
      exp_wr.push_back({6'h3F, 8'hA1});
      tx_bytes.push_back(8'h0A); tx_bytes.push_back(8'h3F);
      tx_bytes.push_back(8'hA1); tx_bytes.push_back(8'hB2);
      frame(0);
      do_read(8'h3F, 8'hA1);
      do_read(8'h00, 8'hAD);

      // Burst read wraps 0x3F -> 0x00
      exp_rd.push_back(8'h00); exp_rd.push_back(8'h00);
      exp_rd.push_back(8'hA1); exp_rd.push_back(8'hAD);
      tx_bytes.push_back(8'h0B); tx_bytes.push_back(8'h3F);
      tx_bytes.push_back(8'hFF); tx_bytes.push_back(8'hFF);
      frame(0);

      // Burst write at the low RAM bound, then burst read back
      repeat (4) exp_rd.push_back(8'h00);
      exp_wr.push_back({6'h10, 8'h3C});
      exp_wr.push_back({6'h11, 8'h4D});
      tx_bytes.push_back(8'h0A); tx_bytes.push_back(8'h10);
      tx_bytes.push_back(8'h3C); tx_bytes.push_back(8'h4D);
      frame(0);
      exp_rd.push_back(8'h00); exp_rd.push_back(8'h00);
      exp_rd.push_back(8'h3C); exp_rd.push_back(8'h4D);
      tx_bytes.push_back(8'h0B); tx_bytes.push_back(8'h10);
      tx_bytes.push_back(8'hFF); tx_bytes.push_back(8'hFF);
      frame(0);

      // Write to a non-writable address is dropped
      repeat (3) exp_rd.push_back(8'h00);
      tx_bytes.push_back(8'h0A); tx_bytes.push_back(8'h05); tx_bytes.push_back(8'h77);
      frame(0);
      do_read(8'h05, 8'h00);

      // Partial data byte aborted by CS high
      exp_rd.push_back(8'h00); exp_rd.push_back(8'h00);
      tx_bytes.push_back(8'h0A); tx_bytes.push_back(8'h21);
      frame(4);
      do_read(8'h21, 8'h00);

      // Live samples and status
      X_DATA = 8'h7E; Y_DATA = 8'h5A; Z_DATA = 8'hC3; DATA_READY = 1'b1;
      do_read(8'h08, 8'h7E);
      do_read(8'h09, 8'h5A);
      do_read(8'h0A, 8'hC3);
      do_read(8'h0B, 8'h01);
      DATA_READY = 1'b0;
      do_read(8'h0B, 8'h00);

      // Unknown command: MISO stays low, nothing written
      repeat (3) exp_rd.push_back(8'h00);
      tx_bytes.push_back(8'h0D); tx_bytes.push_back(8'h12); tx_bytes.push_back(8'h34);
      frame(0);

      // Reset in the middle of reading 0x02 (0xF2)
      exp_rd.push_back(8'h00); exp_rd.push_back(8'h00);
      cs_low();
      xfer_byte(8'h0B, m); got_rd.push_back(m);
      xfer_byte(8'h02, m); got_rd.push_back(m);
      for (int i = 0; i < 3; i++) begin
         xfer_bit(1'b1, mb, 1'b1);
         check("rdata_bit_before_reset", 32'(mb), 1);
      end
      RESET = 1'b1;
      clk_wait(2);
      check("midrst_miso", 32'(MISO), 0);
      check("midrst_miso_oe", 32'(MISO_OE), 0);
      check("midrst_busy", 32'(BUSY), 0);
      check("midrst_wr_strobe", 32'(WR_STROBE), 0);
      check("midrst_wr_addr", 32'(WR_ADDR), 0);
      check("midrst_wr_data", 32'(WR_DATA), 0);
      RESET = 1'b0;
      for (int i = 0; i < 5; i++) begin
         xfer_bit(1'b1, mb, 1'b0);
         check("miso_after_reset", 32'(mb), 0);
      end
      cs_high();
      do_read(8'h01, 8'h1D);
      do_read(8'h20, 8'h00);

      clk_wait(20);
      check("wr_queue_drained", 32'(exp_wr.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
